meta_cache_decode: RTL and testbench

META_CACHE_DECODE -- requirements
Module: meta_cache_decode

---
 rtl/meta_pkg.sv | 28 ++
 rtl/meta_line_store.sv | 66 ++++++
 rtl/meta_cache_decode.sv | 168 ++++++++++++++++
 tb/tb_meta_cache_decode.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/meta_pkg.sv
// Shared types and helpers for the metadata cache: FSM state encoding,
// default parameter values and address-field width helpers.
package meta_pkg;

    localparam int ADDR_W          = 32;
    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_CACHE_DEPTH = 64;
    localparam int DEF_MEM_LATENCY = 1;
    localparam int DEF_CNT_WIDTH   = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_MISS_WAIT,
        ST_RESP
    } state_t;

    // Number of index bits for a direct-mapped cache of the given depth.
    function automatic int idx_width(input int depth);
        return $clog2(depth);
    endfunction

    // Tag bits left over once word offset (2 bits) and index are removed.
    function automatic int tag_width(input int depth);
        return ADDR_W - $clog2(depth) - 2;
    endfunction

endpackage

// File: rtl/meta_line_store.sv
// Line storage for the metadata cache: tag and data arrays (no reset,
// registered read) plus per-line valid bits that reset and flush clear.
module meta_line_store
    import meta_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int CACHE_DEPTH = DEF_CACHE_DEPTH,
    localparam int IDX_W      = idx_width(CACHE_DEPTH),
    localparam int TAG_W      = tag_width(CACHE_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  rd_en,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic                  rd_valid,
    output logic [TAG_W-1:0]      rd_tag,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [TAG_W-1:0]      wr_tag,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid
);

    logic [TAG_W-1:0]      tag_mem  [CACHE_DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [CACHE_DEPTH];
    logic [CACHE_DEPTH-1:0] valid_bits;

    // Fill writes tag and data; old contents are simply overwritten.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_data;
        end
    end

    // Registered read of tag/data, launched when a request is accepted.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_tag  <= tag_mem[rd_idx];
            rd_data <= data_mem[rd_idx];
        end
    end

    // Registered valid read; a flush on the same edge forces a miss.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
        end else if (rd_en) begin
            rd_valid <= valid_bits[rd_idx] & ~flush;
        end
    end

    // Valid bits: flush clears every line and takes priority over a fill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_bits <= '0;
        end else if (flush) begin
            valid_bits <= '0;
        end else if (wr_en) begin
            valid_bits[wr_idx] <= wr_valid;
        end
    end

endmodule

// File: rtl/meta_cache_decode.sv
// Direct-mapped, read-only metadata cache: accepts word lookups, serves hits
// from the line store and refills misses from a fixed-latency memory port.
module meta_cache_decode
    import meta_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int CACHE_DEPTH = DEF_CACHE_DEPTH,
    parameter int MEM_LATENCY = DEF_MEM_LATENCY,
    parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic [31:0]           req_addr,
    output logic                  req_ready,
    output logic                  mem_en,
    output logic [31:0]           mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  meta_valid,
    output logic [DATA_WIDTH-1:0] meta_rdata,
    input  logic                  meta_ready,
    input  logic                  flush,
    output logic [CNT_WIDTH-1:0]  hit_count,
    output logic [CNT_WIDTH-1:0]  miss_count
);

    localparam int IDX_W = idx_width(CACHE_DEPTH);
    localparam int TAG_W = tag_width(CACHE_DEPTH);
    localparam int LAT_W = $clog2(MEM_LATENCY + 1);

    state_t                state_reg, state_next;
    logic [29:0]           word_addr_reg;
    logic [LAT_W-1:0]      lat_cnt_reg;
    logic [DATA_WIDTH-1:0] resp_reg;
    logic                  flush_seen_reg;
    logic [CNT_WIDTH-1:0]  hit_count_reg;
    logic [CNT_WIDTH-1:0]  miss_count_reg;

    logic                  store_rd_valid;
    logic [TAG_W-1:0]      store_rd_tag;
    logic [DATA_WIDTH-1:0] store_rd_data;

    logic accept;
    logic lookup_hit;
    logic lookup_miss;
    logic fill_done;
    logic unused_addr_bits;

    assign unused_addr_bits = ^req_addr[1:0];
    assign accept      = req_valid && req_ready;
    assign lookup_hit  = (state_reg == ST_LOOKUP) && store_rd_valid &&
                         (store_rd_tag == word_addr_reg[29:IDX_W]);
    assign lookup_miss = (state_reg == ST_LOOKUP) && !lookup_hit;
    assign fill_done   = (state_reg == ST_MISS_WAIT) &&
                         (lat_cnt_reg == LAT_W'(MEM_LATENCY - 1));

    assign mem_addr   = {word_addr_reg, 2'b00};
    assign meta_valid = (state_reg == ST_RESP);
    assign meta_rdata = resp_reg;
    assign hit_count  = hit_count_reg;
    assign miss_count = miss_count_reg;

    meta_line_store #(
        .DATA_WIDTH  (DATA_WIDTH),
        .CACHE_DEPTH (CACHE_DEPTH)
    ) u_store (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .rd_en    (accept),
        .rd_idx   (req_addr[IDX_W+1:2]),
        .rd_valid (store_rd_valid),
        .rd_tag   (store_rd_tag),
        .rd_data  (store_rd_data),
        .wr_en    (fill_done),
        .wr_idx   (word_addr_reg[IDX_W-1:0]),
        .wr_tag   (word_addr_reg[29:IDX_W]),
        .wr_data  (mem_rdata),
        .wr_valid (!flush_seen_reg)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic with handshake and memory strobe outputs.
    always_comb begin
        state_next = state_reg;
        req_ready  = 1'b0;
        mem_en     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_next = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                if (lookup_hit) begin
                    state_next = ST_RESP;
                end else begin
                    mem_en     = 1'b1;
                    state_next = ST_MISS_WAIT;
                end
            end
            ST_MISS_WAIT: begin
                if (fill_done) state_next = ST_RESP;
            end
            ST_RESP: begin
                req_ready = meta_ready;
                if (meta_ready) state_next = req_valid ? ST_LOOKUP : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Request address capture and memory latency counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_addr_reg <= '0;
            lat_cnt_reg   <= '0;
        end else begin
            if (accept) word_addr_reg <= req_addr[31:2];
            if (state_reg == ST_LOOKUP) begin
                lat_cnt_reg <= '0;
            end else if (state_reg == ST_MISS_WAIT) begin
                lat_cnt_reg <= lat_cnt_reg + 1'b1;
            end
        end
    end

    // Response register, loaded from the line on a hit or from memory on a fill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_reg <= '0;
        end else if (lookup_hit) begin
            resp_reg <= store_rd_data;
        end else if (fill_done) begin
            resp_reg <= mem_rdata;
        end
    end

    // Remember a flush seen while a miss is outstanding so the fill stays invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_seen_reg <= 1'b0;
        end else if (accept) begin
            flush_seen_reg <= 1'b0;
        end else if (flush) begin
            flush_seen_reg <= 1'b1;
        end
    end

    // Saturating hit/miss statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count_reg  <= '0;
            miss_count_reg <= '0;
        end else begin
            if (lookup_hit && (hit_count_reg != '1)) hit_count_reg <= hit_count_reg + 1'b1;
            if (lookup_miss && (miss_count_reg != '1)) miss_count_reg <= miss_count_reg + 1'b1;
        end
    end

endmodule

// File: tb/tb_meta_cache_decode.sv
// Directed bench for meta_cache_decode (4 lines, 3-cycle memory): a
// scoreboard queue holds expected response data, popped on each handshake.
module tb_meta_cache_decode;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        mem_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        meta_valid;
    logic [31:0] meta_rdata;
    logic        meta_ready;
    logic        flush;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int total = 0;
    int bad   = 0;
    int exp_hits = 0;
    int exp_misses = 0;

    logic [31:0] sb [$];

    logic        acc_s, mem_en_s, hs_s, mv_s;
    logic [31:0] mem_addr_s;

    logic [1:0]  pend_v;
    logic [31:0] pend_a0, pend_a1;

    meta_cache_decode #(
        .DATA_WIDTH  (32),
        .CACHE_DEPTH (4),
        .MEM_LATENCY (3),
        .CNT_WIDTH   (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .mem_en     (mem_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .meta_valid (meta_valid),
        .meta_rdata (meta_rdata),
        .meta_ready (meta_ready),
        .flush      (flush),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'hA5A5_A5A5;
        return (a * 32'h0001_0003) ^ 32'h3C5A_0000;
    endfunction

    // Memory model: data for a strobe at edge k is presented for edge k+3.
    always @(posedge clk) begin
        if (pend_v[1]) mem_rdata <= mdata(pend_a1);
        else           mem_rdata <= 32'hDEAD_BEEF;
        pend_v  <= {pend_v[0], mem_en};
        pend_a1 <= pend_a0;
        pend_a0 <= mem_addr;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Sample just before the coming edge, score any handshake, then cross it.
    task automatic tick();
        logic [31:0] e;
        #1;
        acc_s      = req_valid && req_ready;
        mem_en_s   = mem_en;
        mem_addr_s = mem_addr;
        mv_s       = meta_valid;
        hs_s       = meta_valid && meta_ready;
        if (hs_s) begin
            e = (sb.size() != 0) ? sb.pop_front() : 32'hBAD0_0000;
            check("resp_data", meta_rdata, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_req(input logic [31:0] a, input int exp_lat, input bit exp_miss, input int flush_at);
        int n, lat, nmem, mem_tick;
        bit acc, got;
        logic [31:0] maddr;
        sb.push_back(mdata({a[31:2], 2'b00}));
        req_valid = 1'b1;
        req_addr  = a;
        meta_ready = 1'b1;
        n = 0; acc = 1'b0;
        while (!acc && n < 20) begin
            tick();
            acc = acc_s;
            n++;
        end
        check("accept", acc, 1);
        req_valid = 1'b0;
        lat = 0; got = 1'b0; nmem = 0; mem_tick = 0; maddr = '0;
        while (!got && lat < 40) begin
            lat++;
            flush = (lat == flush_at);
            tick();
            flush = 1'b0;
            if (mem_en_s) begin
                nmem++;
                mem_tick = lat;
                maddr = mem_addr_s;
            end
            got = hs_s;
        end
        check("resp_seen", got, 1);
        check("latency", lat, exp_lat);
        if (exp_miss) begin
            exp_misses++;
            check("mem_en_count", nmem, 1);
            check("mem_en_cycle", mem_tick, 1);
            check("mem_addr", maddr, {a[31:2], 2'b00});
        end else begin
            exp_hits++;
            check("no_mem_en", nmem, 0);
        end
        check("hit_count", hit_count, exp_hits);
        check("miss_count", miss_count, exp_misses);
        $display("req addr=%h miss=%0d latency=%0d hits=%0d misses=%0d", a, exp_miss, lat, hit_count, miss_count);
    endtask

    initial begin
        logic [31:0] held;
        int n;
        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; meta_ready = 1'b1; flush = 1'b0;
        pend_v = '0; pend_a0 = '0; pend_a1 = '0; mem_rdata = '0;
        #12;
        check("rst_meta_valid", meta_valid, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_meta_rdata", meta_rdata, 0);
        check("rst_hit", hit_count, 0);
        check("rst_miss", miss_count, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_req_ready", req_ready, 1);

        // Cold miss, hit, ignored low address bits.
        run_req(32'h0000_0100, 5, 1'b1, -1);
        run_req(32'h0000_0100, 2, 1'b0, -1);
        run_req(32'h0000_0103, 2, 1'b0, -1);
        // Conflict eviction on index 0.
        run_req(32'h0000_0110, 5, 1'b1, -1);
        run_req(32'h0000_0100, 5, 1'b1, -1);

        // Backpressure: response held for 4 cycles, next request waits.
        sb.push_back(mdata(32'h0000_0100));
        req_valid = 1'b1; req_addr = 32'h0000_0100; meta_ready = 1'b0;
        tick();
        check("bp_accept", acc_s, 1);
        req_valid = 1'b0;
        n = 0;
        do begin tick(); n++; end while (!mv_s && n < 20);
        check("bp_latency", n, 2);
        held = meta_rdata;
        sb.push_back(mdata(32'h0000_0100));
        req_valid = 1'b1; req_addr = 32'h0000_0103;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("bp_meta_valid", mv_s, 1);
            check("bp_meta_rdata", meta_rdata, held);
            check("bp_req_ready", acc_s, 0);
        end
        meta_ready = 1'b1;
        tick();
        check("bp_release_hs", hs_s, 1);
        check("bp_release_accept", acc_s, 1);
        req_valid = 1'b0;
        n = 0;
        do begin tick(); n++; end while (!hs_s && n < 20);
        check("bp_next_latency", n, 2);
        exp_hits += 2;
        check("bp_hit_count", hit_count, exp_hits);
        $display("backpressure held=%h hits=%0d", held, hit_count);

        // Flush during MISS_WAIT, then on the fill edge: line stays invalid.
        run_req(32'h0000_0204, 5, 1'b1, 2);
        run_req(32'h0000_0204, 5, 1'b1, -1);
        run_req(32'h0000_0204, 2, 1'b0, -1);
        run_req(32'h0000_0208, 5, 1'b1, 4);
        run_req(32'h0000_0208, 5, 1'b1, -1);

        // Reset in MISS_WAIT: stale memory data must not surface.
        req_valid = 1'b1; req_addr = 32'h0000_0300;
        tick();
        check("rm_accept", acc_s, 1);
        req_valid = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("rm_meta_valid", meta_valid, 0);
        check("rm_mem_en", mem_en, 0);
        check("rm_hit", hit_count, 0);
        check("rm_miss", miss_count, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        exp_hits = 0; exp_misses = 0;
        check("rm_req_ready", req_ready, 1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("rm_stale_meta_valid", mv_s, 0);
        end
        $display("reset mid-miss hits=%0d misses=%0d", hit_count, miss_count);
        run_req(32'h0000_0100, 5, 1'b1, -1);
        check("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
